// File: rtl/paint_brush.sv
// Paint brush stroke engine: decodes button press edges into pen/brush/erase
// changes and walks an NxN square brush over a framebuffer write port.
module paint_brush #(
  parameter int COORD_W   = 6,
  parameter int COLOR_W   = 8,
  parameter int MAX_BRUSH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [2:0]         in_button,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [COLOR_W-1:0] px_data,
  output logic               paint,
  output logic               busy,
  output logic               done,
  output logic [COLOR_W-1:0] color,
  output logic [3:0]         brush,
  output logic               erase
);

  localparam int CW1 = COORD_W + 1;

  localparam logic [2:0] BTN_NONE   = 3'b000;
  localparam logic [2:0] BTN_ERASE  = 3'b001;
  localparam logic [2:0] BTN_STROKE = 3'b010;
  localparam logic [2:0] BTN_BRUSH  = 3'b011;
  localparam logic [2:0] BTN_COLOR  = 3'b100;

  localparam logic [COLOR_W-1:0] COLOR_ONE = 1;
  localparam logic [3:0]         BRUSH_MAX = 4'(MAX_BRUSH);
  localparam logic [3:0]         ONE4      = 4'd1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROKE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]         r_prev_btn;
  logic [COORD_W-1:0] r_ox;
  logic [COORD_W-1:0] r_oy;
  logic [3:0]         r_n;
  logic [3:0]         r_dx;
  logic [3:0]         r_dy;
  logic [COORD_W-1:0] r_out_x;
  logic [COORD_W-1:0] r_out_y;
  logic [COLOR_W-1:0] r_px;
  logic               r_paint;
  logic [COLOR_W-1:0] r_color;
  logic [3:0]         r_brush;
  logic               r_erase;

  logic           w_press;
  logic           w_accept;
  logic           w_cmd_stroke;
  logic           w_advance;
  logic           w_row_end;
  logic           w_last;
  logic [3:0]     w_ndx;
  logic [3:0]     w_ndy;
  logic [CW1-1:0] w_sum_x;
  logic [CW1-1:0] w_sum_y;
  logic           w_in_range;

  // A press is a nonzero code following a released (000) cycle; holding a
  // button never re-triggers, including across the return to IDLE.
  assign w_press      = (in_button != BTN_NONE) && (r_prev_btn == BTN_NONE);
  assign w_accept     = w_press && init && (r_state == S_IDLE);
  assign w_cmd_stroke = w_accept && (in_button == BTN_STROKE);

  // Skip cycles (paint=0) advance unconditionally; writes wait for wr_ready.
  assign w_advance = (r_state == S_STROKE) && (!r_paint || wr_ready);
  assign w_row_end = (r_dx == r_n - ONE4);
  assign w_last    = w_row_end && (r_dy == r_n - ONE4);
  assign w_ndx     = w_row_end ? 4'd0 : r_dx + ONE4;
  assign w_ndy     = w_row_end ? r_dy + ONE4 : r_dy;

  // One extra bit catches pixels past the canvas edge instead of wrapping.
  assign w_sum_x    = CW1'(r_ox) + CW1'(w_ndx);
  assign w_sum_y    = CW1'(r_oy) + CW1'(w_ndy);
  assign w_in_range = !w_sum_x[COORD_W] && !w_sum_y[COORD_W];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_cmd_stroke) w_next = S_STROKE;
      S_STROKE: if (w_advance && w_last) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_btn <= BTN_NONE;
      r_ox       <= '0;
      r_oy       <= '0;
      r_n        <= ONE4;
      r_dx       <= '0;
      r_dy       <= '0;
      r_out_x    <= '0;
      r_out_y    <= '0;
      r_px       <= '0;
      r_paint    <= 1'b0;
      r_color    <= COLOR_ONE;
      r_brush    <= ONE4;
      r_erase    <= 1'b0;
    end else begin
      r_prev_btn <= in_button;
      if (w_accept) begin
        case (in_button)
          BTN_COLOR: r_color <= (r_color == '1) ? COLOR_ONE : r_color + COLOR_ONE;
          BTN_BRUSH: r_brush <= (r_brush >= BRUSH_MAX) ? ONE4 : r_brush + ONE4;
          BTN_ERASE: r_erase <= ~r_erase;
          BTN_STROKE: begin
            // Offset (0,0) is always on canvas, so the first request is
            // loaded directly from the cursor on the accept edge.
            r_ox    <= in_x;
            r_oy    <= in_y;
            r_n     <= r_brush;
            r_dx    <= '0;
            r_dy    <= '0;
            r_out_x <= in_x;
            r_out_y <= in_y;
            r_px    <= r_erase ? '0 : r_color;
            r_paint <= 1'b1;
          end
          default: ;
        endcase
      end else if (w_advance) begin
        if (w_last) begin
          r_paint <= 1'b0;
        end else begin
          r_dx    <= w_ndx;
          r_dy    <= w_ndy;
          r_paint <= w_in_range;
          if (w_in_range) begin
            r_out_x <= w_sum_x[COORD_W-1:0];
            r_out_y <= w_sum_y[COORD_W-1:0];
          end
        end
      end
    end
  end

  assign out_x   = r_out_x;
  assign out_y   = r_out_y;
  assign px_data = r_px;
  assign paint   = r_paint;
  assign busy    = (r_state == S_STROKE);
  assign done    = (r_state == S_FINISH);
  assign color   = r_color;
  assign brush   = r_brush;
  assign erase   = r_erase;

endmodule

// File: doc/paint_brush.md
PAINT_BRUSH -- requirements
Module: paint_brush

Interface
REQ-001 SHALL have parameter COORD_W, default 6, meaning coordinate width in bits (canvas 2^COORD_W x 2^COORD_W).
REQ-002 SHALL have parameter COLOR_W, default 8, meaning pixel colour width in bits.
REQ-003 SHALL have parameter MAX_BRUSH, default 4, meaning maximum square brush edge in pixels (range 1..8).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port init, input, 1 bit: enables command acceptance when high.
REQ-007 SHALL have port in_button, input, 3 bits: button code, where 000 means none.
REQ-008 SHALL have ports in_x and in_y, inputs, COORD_W bits each: cursor position.
REQ-009 SHALL have port wr_ready, input, 1 bit: the framebuffer accepts the current write.
REQ-010 SHALL have ports out_x and out_y, outputs, COORD_W bits each: write address.
REQ-011 SHALL have port px_data, output, COLOR_W bits: write colour.
REQ-012 SHALL have port paint, output, 1 bit: write request strobe.
REQ-013 SHALL have port busy, output, 1 bit: stroke in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at stroke completion.
REQ-015 SHALL have port color, output, COLOR_W bits: current pen colour.
REQ-016 SHALL have port brush, output, 4 bits: current brush edge.
REQ-017 SHALL have port erase, output, 1 bit: erase mode active.

Function
REQ-018 SHALL accept a command only on a press edge: in_button nonzero while the previous cycle's in_button was 000, with init high and the FSM in IDLE; no other condition accepts a command.
REQ-019 SHALL decode 100 as colour-next: color+1, wrapping 2^COLOR_W-1 to 1, never 0.
REQ-020 SHALL decode 011 as brush-next: brush+1, wrapping MAX_BRUSH to 1.
REQ-021 SHALL decode 001 as toggling erase.
REQ-022 SHALL decode 010 as starting a stroke.
REQ-023 SHALL ignore all other codes.
REQ-024 SHALL apply colour-next, brush-next and erase changes on the cycle after the edge, with the FSM staying in IDLE.
REQ-025 SHALL use FSM states IDLE, STROKE and FINISH.
REQ-026 SHALL, on stroke accept, latch in_x/in_y as origin (ox,oy), latch brush as edge N, and latch px_data = erase ? 0 : color, then go IDLE->STROKE with busy=1 the next cycle.
REQ-027 SHALL, in STROKE, visit N*N offsets (dx,dy) row-major, dx fastest, from (0,0) to (N-1,N-1).
REQ-028 SHALL present out_x=ox+dx and out_y=oy+dy at COORD_W+1 bit precision for each offset.
REQ-029 SHALL, if either sum exceeds 2^COORD_W-1, skip that pixel with no wrap: paint=0 for exactly one cycle, then advance.
REQ-030 SHALL, for an in-range pixel, assert paint=1 and hold out_x, out_y and px_data stable until a cycle with wr_ready=1, then advance the next cycle.
REQ-031 SHALL NOT stall the FSM on wr_ready while paint=0.
REQ-032 SHALL, after the last offset is written or skipped, go STROKE->FINISH, and in FINISH drive paint=0, busy=0 and done=1 for one cycle, then go to IDLE.
REQ-033 SHALL give a first write request exactly 1 cycle after the accept cycle.
REQ-034 SHALL make a full in-range stroke with wr_ready held high take N*N cycles in STROKE.
REQ-035 SHALL NOT abort a stroke when init falls mid-stroke; the stroke completes.
REQ-036 SHALL ignore button edges during STROKE and FINISH; they are not queued.
REQ-037 SHALL NOT treat a button held across the return to IDLE as a new edge.
REQ-038 SHALL keep out_x, out_y and px_data at their last values when paint=0.

Reset
REQ-039 SHALL, on rst high at a rising edge, force FSM=IDLE, out_x=0, out_y=0, px_data=0, paint=0, busy=0, done=0, color=1, brush=1, erase=0, and previous-button register=000.
REQ-040 SHALL give rst priority over all other inputs, including mid-stroke, where the pending write is dropped and paint is 0 the next cycle.

Verification
REQ-041 SHALL cover: reset, then press 010 at (10,20) with wr_ready=1 -> exactly one write (10,20,px_data=1), then done pulse, busy high for 1 cycle.
REQ-042 SHALL cover: three 011 presses, then 010 at (5,5) -> brush=4, 16 writes x=5..8, y=5..8 row-major, colour 1.
REQ-043 SHALL cover: brush=4, stroke at (62,63) with COORD_W=6 -> only (62,63) and (63,63) written, 14 skip cycles, no wrapped addresses.
REQ-044 SHALL cover: wr_ready low for 5 cycles on the first write -> paint and address held for 6 cycles, one write counted.
REQ-045 SHALL cover: 255 presses of 100 with COLOR_W=8 -> color wraps 255->1; then 001 and stroke -> px_data=0.
REQ-046 SHALL cover: rst asserted on the 3rd write of a 4x4 stroke -> next cycle paint=0 and busy=0, with brush=1 and color=1.
